clock_set_ctrl: RTL
===================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 30, ticks of no accepted press in a set state before abandoning the edit.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 tick  in  1  one-cycle 1 Hz enable pulse; same pulse that drives the clock datapath.
REQ-005 btn_mode  in  1  synchronised, debounced mode button level.
REQ-006 btn_inc  in  1  synchronised, debounced increment button level.
REQ-007 hh_in, mm_in, ss_in  in  6 each  current time from the clock datapath.
REQ-008 run_en  out  1  count enable to the clock datapath.
REQ-009 load  out  1  one-cycle strobe: datapath loads hh_set/mm_set/ss_set.
REQ-010 hh_set, mm_set, ss_set  out  6 each  edit registers, driven continuously.
REQ-011 sel  out  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds.
REQ-012 blink  out  1  display blink phase for the selected field.

Function
REQ-013 A press is the rising edge of a button level: level=1 in cycle N while the registered previous level=0; the press is acted on at the end of cycle N.
REQ-014 The FSM has states RUN, SET_HH, SET_MM, SET_SS, LOAD; sel = 0, 1, 2, 3, 0 respectively.
REQ-015 RUN: run_en=1, load=0, blink=0; a mode press captures hh_in/mm_in/ss_in into the edit registers and moves to SET_HH.
REQ-016 SET_HH -> SET_MM -> SET_SS on a mode press; run_en=0 in every set state.
REQ-017 SET_SS, mode press -> LOAD.
REQ-018 LOAD lasts exactly one cycle with load=1 and run_en=0, then RUN with run_en=1 from the next cycle.
REQ-019 An inc press in a set state increments only the selected edit register: hours wrap 23->0, minutes and seconds wrap 59->0.
REQ-020 Inc presses in RUN or LOAD are ignored.
REQ-021 A mode press and an inc press in the same cycle: mode wins, inc is dropped.
REQ-022 Timeout counter: cleared on entry to SET_HH and on every accepted press; otherwise increments on tick in set states.
REQ-023 When a tick arrives with the timeout counter at TIMEOUT-1, the FSM returns to RUN with no load pulse, and the edit registers hold their values.
REQ-024 A press in the same cycle as the timeout tick wins; timeout is cancelled.
REQ-025 blink toggles on each tick while in a set state; it is forced to 0 on entry to SET_HH and in RUN and LOAD.
REQ-026 tick is ignored for edit arithmetic; edit registers change only on capture (REQ-015) or inc (REQ-019).
REQ-027 Button levels held high produce one press only; there is no auto-repeat.

Reset
REQ-028 While reset=0, and until the first clk edge after release, the outputs are: state RUN, run_en=1, load=0, sel=0, blink=0, hh_set=mm_set=ss_set=0, timeout counter 0, both previous-level registers 0.
REQ-029 Reset asserted mid-edit (any set state or LOAD) aborts to RUN immediately with no load pulse.
REQ-030 A button already high at reset release registers as a press on the first clock edge after release.

Verification
REQ-031 Time 12:34:56, mode, then 3 inc presses in SET_HH, mode, mode, mode -> load=1 for one cycle with hh_set=15, mm_set=34, ss_set=56; run_en=0 from the first press through the LOAD cycle.
REQ-032 Wrap: hh_in=23, enter SET_HH, inc -> hh_set=0; in SET_MM with mm_set=59, inc -> 0; in SET_SS with ss_set=59, inc -> 0.
REQ-033 Timeout: enter SET_MM, then 30 ticks with no press -> RUN after the 30th tick, load never asserted, run_en=1.
REQ-034 btn_mode and btn_inc rise in the same cycle in SET_HH -> SET_MM, hh_set unchanged.
REQ-035 Reset pulse while in SET_SS -> RUN, sel=0, edit registers 0, no load pulse.
REQ-036 btn_inc held high for 100 cycles in SET_SS -> exactly one increment.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//   Mode/increment button controller for setting an hh:mm:ss clock.
//   A mode press in RUN copies the live time into edit registers. Further mode
//   presses step through hours, minutes and seconds. A mode press on seconds
//   issues a one-cycle load strobe to the datapath. Inc presses bump the
//   selected field. An edit with no accepted press for TIMEOUT ticks is
//   abandoned without a load.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   tick       in   1 Hz one-cycle enable pulse
//   btn_mode   in   debounced mode button level
//   btn_inc    in   debounced increment button level
//   hh_in      in   [5:0] live hours from the datapath
//   mm_in      in   [5:0] live minutes from the datapath
//   ss_in      in   [5:0] live seconds from the datapath
//   run_en     out  datapath count enable (high only in RUN)
//   load       out  one-cycle strobe: datapath takes hh_set/mm_set/ss_set
//   hh_set     out  [5:0] hours edit register
//   mm_set     out  [5:0] minutes edit register
//   ss_set     out  [5:0] seconds edit register
//   sel        out  [1:0] field being edited: 0 none, 1 hh, 2 mm, 3 ss
//   blink      out  blink phase for the selected field
//   state_dbg  out  [2:0] current FSM state encoding
//
// Handshake: there is no valid/ready pairing here. A press is accepted in the
// cycle where the button level is 1 and its registered previous level is 0.
// load is a single-cycle strobe with no backpressure.
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] hh_in,
  input  logic [5:0] mm_in,
  input  logic [5:0] ss_in,
  output logic       run_en,
  output logic       load,
  output logic [5:0] hh_set,
  output logic [5:0] mm_set,
  output logic [5:0] ss_set,
  output logic [1:0] sel,
  output logic       blink,
  output logic [2:0] state_dbg
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    SET_SS = 3'd3,
    LOAD   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_mode_prev;
  logic          r_inc_prev;
  logic [TW-1:0] r_to_cnt;
  logic          r_blink;
  logic [5:0]    r_hh;
  logic [5:0]    r_mm;
  logic [5:0]    r_ss;

  logic w_mode_press;
  logic w_inc_press;
  logic w_in_set;
  logic w_timeout;

  assign w_mode_press = btn_mode & ~r_mode_prev;
  assign w_inc_press  = btn_inc  & ~r_inc_prev;
  assign w_in_set     = (r_state == SET_HH) || (r_state == SET_MM) ||
                        (r_state == SET_SS);
  assign w_timeout    = tick && (r_to_cnt == TO_LAST);

  // Next-state logic. Any accepted press cancels a coinciding timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_mode_press) w_state_next = SET_HH;
      end
      SET_HH: begin
        if (w_mode_press)                    w_state_next = SET_MM;
        else if (w_timeout && !w_inc_press)  w_state_next = RUN;
      end
      SET_MM: begin
        if (w_mode_press)                    w_state_next = SET_SS;
        else if (w_timeout && !w_inc_press)  w_state_next = RUN;
      end
      SET_SS: begin
        if (w_mode_press)                    w_state_next = LOAD;
        else if (w_timeout && !w_inc_press)  w_state_next = RUN;
      end
      LOAD:    w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // Moore outputs, decoded from the state register.
  always_comb begin
    run_en = 1'b0;
    load   = 1'b0;
    sel    = 2'd0;
    case (r_state)
      RUN:     run_en = 1'b1;
      SET_HH:  sel    = 2'd1;
      SET_MM:  sel    = 2'd2;
      SET_SS:  sel    = 2'd3;
      LOAD:    load   = 1'b1;
      default: run_en = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_mode_prev <= 1'b0;
      r_inc_prev  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mode_prev <= btn_mode;
      r_inc_prev  <= btn_inc;
    end
  end

  // Inactivity counter. Only meaningful in set states; cleared everywhere
  // else so entry to SET_HH always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (!w_in_set || w_mode_press || w_inc_press || w_timeout) begin
      r_to_cnt <= '0;
    end else if (tick) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Blink phase: zero outside the set states and when leaving them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink <= 1'b0;
    end else if (!w_in_set || (w_state_next == RUN) || (w_state_next == LOAD)) begin
      r_blink <= 1'b0;
    end else if (tick) begin
      r_blink <= ~r_blink;
    end
  end

  // Edit registers: capture on edit entry, increment on inc in a set state.
  // A simultaneous mode press takes priority and drops the inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
    end else if ((r_state == RUN) && w_mode_press) begin
      r_hh <= hh_in;
      r_mm <= mm_in;
      r_ss <= ss_in;
    end else if (w_in_set && w_inc_press && !w_mode_press) begin
      case (r_state)
        SET_HH:  r_hh <= (r_hh >= 6'd23) ? 6'd0 : r_hh + 6'd1;
        SET_MM:  r_mm <= (r_mm >= 6'd59) ? 6'd0 : r_mm + 6'd1;
        SET_SS:  r_ss <= (r_ss >= 6'd59) ? 6'd0 : r_ss + 6'd1;
        default: ;
      endcase
    end
  end

  assign hh_set    = r_hh;
  assign mm_set    = r_mm;
  assign ss_set    = r_ss;
  assign blink     = r_blink;
  assign state_dbg = r_state;

endmodule
